full_adder_1b: RTL and testbench

- 1-bit full-adder cell. Its combinational sum/carry outputs serve as the basic arithmetic leaf in ripple adders.
- It adds a registered output stage and an optional bit-serial mode. In that mode the carry register feeds back as carry-in, so multi-bit words can be added LSB-first over successive cycles.
- It sits beneath wider adder/ALU blocks and in serial arithmetic datapaths.

---
 rtl/fa_pkg.sv | 16 +
 rtl/fa_cell.sv | 18 +
 rtl/full_adder_1b.sv | 77 +++++++
 tb/tb_full_adder_1b.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Shared types and the full-adder equation used by the adder cell.
package fa_pkg;

  typedef struct packed {
    logic s;
    logic c;
  } fa_res_t;

  function automatic fa_res_t fa_add(input logic a, input logic b, input logic ci);
    fa_res_t r;
    r.s = a ^ b ^ ci;
    r.c = (a & b) | (a & ci) | (b & ci);
    return r;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full-adder leaf.
module fa_cell
  import fa_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  fa_res_t w_res;

  assign w_res = fa_add(a, b, ci);
  assign s     = w_res.s;
  assign co    = w_res.c;

endmodule

// File: rtl/full_adder_1b.sv
// 1-bit full adder with a registered output stage and an LSB-first bit-serial mode.
// The serial mode feeds the carry register back into the cell's carry-in.
module full_adder_1b
  import fa_pkg::*;
#(
  parameter int BIT_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 A,
  input  logic                 B,
  input  logic                 Cin,
  input  logic                 serial_en,
  input  logic                 in_valid,
  input  logic                 clr,
  output logic                 S,
  output logic                 Cout,
  output logic                 S_q,
  output logic                 Cout_q,
  output logic                 out_valid,
  output logic                 carry_q,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  logic                 w_cin_eff;
  logic                 w_s;
  logic                 w_co;
  logic                 r_s;
  logic                 r_co;
  logic                 r_valid;
  logic                 r_carry;
  logic [BIT_CNT_W-1:0] r_cnt;

  // The carry source switches immediately with serial_en; r_carry is never touched by the switch.
  assign w_cin_eff = serial_en ? r_carry : Cin;

  fa_cell u_fa_cell (
    .a  (A),
    .b  (B),
    .ci (w_cin_eff),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= 1'b0;
      r_co    <= 1'b0;
      r_valid <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_s  <= w_s;
        r_co <= w_co;
      end
      // clr wins over a same-cycle serial update; the output stage still captures.
      if (clr) begin
        r_carry <= 1'b0;
        r_cnt   <= '0;
      end else if (in_valid && serial_en) begin
        r_carry <= w_co;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign S         = w_s;
  assign Cout      = w_co;
  assign S_q       = r_s;
  assign Cout_q    = r_co;
  assign out_valid = r_valid;
  assign carry_q   = r_carry;
  assign bit_cnt   = r_cnt;

endmodule

// File: tb/tb_full_adder_1b.sv
// Self-checking bench for full_adder_1b: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_full_adder_1b;

  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          A, B, Cin, serial_en, in_valid, clr;
  logic          S, Cout, S_q, Cout_q, out_valid, carry_q;
  logic [CW-1:0] bit_cnt;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  logic m_sq, m_cq, m_ov, m_carry;
  int   m_cnt;

  logic [0:0] exp_q[$];

  full_adder_1b #(.BIT_CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .serial_en (serial_en),
    .in_valid  (in_valid),
    .clr       (clr),
    .S         (S),
    .Cout      (Cout),
    .S_q       (S_q),
    .Cout_q    (Cout_q),
    .out_valid (out_valid),
    .carry_q   (carry_q),
    .bit_cnt   (bit_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // arithmetic model: total = a + b + cin, sum bit is total mod 2, carry is total div 2
  function automatic int model_total();
    int cin;
    cin = serial_en ? int'(m_carry) : int'(Cin);
    return int'(A) + int'(B) + cin;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sq <= 1'b0; m_cq <= 1'b0; m_ov <= 1'b0; m_carry <= 1'b0; m_cnt <= 0;
    end else begin
      m_ov <= in_valid;
      if (in_valid) begin
        m_sq <= (model_total() % 2) == 1;
        m_cq <= (model_total() / 2) == 1;
      end
      if (clr) begin
        m_carry <= 1'b0;
        m_cnt   <= 0;
      end else if (in_valid && serial_en) begin
        m_carry <= (model_total() / 2) == 1;
        m_cnt   <= (m_cnt + 1) % (1 << CW);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // driver tasks
  task automatic drive(input logic a, input logic b, input logic ci,
                       input logic se, input logic iv, input logic c);
    A = a; B = b; Cin = ci; serial_en = se; in_valid = iv; clr = c;
  endtask

  task automatic check_comb(input string tag);
    #1;
    check({tag, "_S"},    32'(S),    32'((model_total() % 2)));
    check({tag, "_Cout"}, 32'(Cout), 32'((model_total() / 2)));
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_S_q"},       32'(S_q),       32'(m_sq));
    check({tag, "_Cout_q"},    32'(Cout_q),    32'(m_cq));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(m_ov));
    check({tag, "_carry_q"},   32'(carry_q),   32'(m_carry));
    check({tag, "_bit_cnt"},   32'(bit_cnt),   32'(m_cnt));
  endtask

  // drive, check combinational outputs, take one edge
  task automatic cycle(input string tag, input logic a, input logic b, input logic ci,
                       input logic se, input logic iv, input logic c);
    drive(a, b, ci, se, iv, c);
    check_comb(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] sum;
    logic [3:0] wa, wb;
    logic [2:0] v;

    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    check("rst_S_q", 32'(S_q), 0);
    check("rst_Cout_q", 32'(Cout_q), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_carry_q", 32'(carry_q), 0);
    check("rst_bit_cnt", 32'(bit_cnt), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // truth table against constants, in_valid=0, every 10 time units
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v[2], v[1], v[0], 0, 0, 0);
      #10;
      check($sformatf("tt%0d_S", i),    32'(S),    32'(v[2] ^ v[1] ^ v[0]));
      check($sformatf("tt%0d_Cout", i), 32'(Cout), 32'(int'(v[2]) + int'(v[1]) + int'(v[0]) >= 2));
    end
    @(posedge clk); #1;
    check_regs("tt_regs");

    // registered path
    cycle("reg1", 1, 1, 1, 0, 1, 0);
    check("reg1_S_q", 32'(S_q), 1);
    check("reg1_Cout_q", 32'(Cout_q), 1);
    check("reg1_out_valid", 32'(out_valid), 1);
    cycle("reg0", 0, 0, 0, 0, 0, 0);
    check("reg0_out_valid", 32'(out_valid), 0);
    check("reg0_S_q_hold", 32'(S_q), 1);
    check("reg0_Cout_q_hold", 32'(Cout_q), 1);

    // serial add 0xB + 0x7, LSB first
    cycle("sclr", 0, 0, 0, 0, 0, 1);
    wa = 4'hB; wb = 4'h7;
    sum = 5'(wa) + 5'(wb);
    for (int i = 0; i < 4; i++) exp_q.push_back(sum[i]);
    for (int i = 0; i < 4; i++) begin
      drive(wa[i], wb[i], 0, 1, 1, 0);
      #1;
      check($sformatf("ser%0d_S", i), 32'(S), 32'(exp_q.pop_front()));
      @(posedge clk); #1;
    end
    check("ser_carry_q", 32'(carry_q), 32'(sum[4]));
    check("ser_bit_cnt", 32'(bit_cnt), 4);
    check_regs("ser_regs");

    // clr priority with carry_q=1; comb outputs still see old carry
    cycle("clrp", 1, 1, 0, 1, 1, 1);
    check("clrp_carry_q", 32'(carry_q), 0);
    check("clrp_bit_cnt", 32'(bit_cnt), 0);
    check("clrp_S_q", 32'(S_q), 1);
    check("clrp_Cout_q", 32'(Cout_q), 1);

    // counter wrap over 256 serial valid cycles
    for (int i = 0; i < 256; i++) begin
      cycle("wrap", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1, 1, 0);
      if (i == 254) check("wrap_cnt_255", 32'(bit_cnt), 255);
    end
    check("wrap_bit_cnt", 32'(bit_cnt), 0);
    check_regs("wrap_regs");

    // randomized mixed traffic
    for (int i = 0; i < 300; i++) begin
      cycle("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      check_regs("rnd");
    end

    // asynchronous reset mid-cycle after activity
    drive(1, 1, 1, 1, 1, 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_S_q", 32'(S_q), 0);
    check("arst_Cout_q", 32'(Cout_q), 0);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_carry_q", 32'(carry_q), 0);
    check("arst_bit_cnt", 32'(bit_cnt), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_regs("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
